delay_sched: RTL and testbench
==============================

DELAY_SCHED -- requirements
Module: delay_sched

Interface
- REQ-001: Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
- REQ-002: Parameter CW, default 4, SHALL set the width of the shared delay counter.
- REQ-003: clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  SHALL be the asynchronous, active-high reset.
- REQ-005: req  input  NREQ  SHALL carry one level request per requester, held until done or abort.
- REQ-006: len  input  NREQ*CW  SHALL carry the requested delay; requester i uses slice [i*CW +: CW].
- REQ-007: gnt  output  NREQ  SHALL be one-hot or zero, and SHALL mark the requester that owns the counter.
- REQ-008: done  output  NREQ  SHALL carry a one-cycle completion pulse to the owning requester.
- REQ-009: busy  output  1  SHALL be high whenever the state is not IDLE.
- REQ-010: cnt  output  CW  SHALL expose the shared counter value.

Function
- REQ-011: The FSM SHALL have three states: IDLE, RUN and DONE.
- REQ-012: In IDLE with any req bit high, the block SHALL grant round-robin, starting at index ptr+1 mod NREQ.
- REQ-013: On that grant it SHALL latch the winner's len into L, clear cnt, update ptr to the winner, and enter RUN.
- REQ-014: In IDLE with req all zero, the block SHALL stay in IDLE with gnt=0.
- REQ-015: In RUN, gnt SHALL equal the winner's one-hot code, and cnt SHALL increment by 1 each cycle modulo 2^CW.
- REQ-016: RUN SHALL exit to DONE in the cycle where cnt == L-1 (mod 2^CW), so RUN lasts exactly L cycles.
- REQ-017: L=0 SHALL mean 2^CW cycles, because the counter wraps to all-ones.
- REQ-018: DONE SHALL last one cycle, with done[winner]=1, gnt=0, and cnt holding its final value; the next state SHALL be IDLE.
- REQ-019: Latency SHALL be as follows, for a request sampled in IDLE at cycle 0:
  - gnt high in cycles 1..L;
  - done pulse in cycle L+1;
  - next arbitration in cycle L+2.
- REQ-020: req and len SHALL be ignored outside IDLE, except as stated in REQ-024.
- REQ-021: A requester still asserting req in IDLE after its done pulse SHALL be treated as a new request, and SHALL lose to any other requester per round-robin.
- REQ-022: Any req bit changing while the FSM is in RUN or DONE SHALL NOT disturb the current grant.

Reset
- REQ-023: While rst is high, the block SHALL hold:
  - state=IDLE;
  - ptr=NREQ-1, so requester 0 has first priority;
  - L=0, cnt=0, gnt=0, done=0, busy=0.
  Reset asserted mid-RUN SHALL abort immediately with no done pulse.

Configuration
- REQ-024: With macro DELAY_SCHED_ABORT_EN defined:
  - req[winner] low during RUN SHALL move the FSM to IDLE on the next edge;
  - no done pulse SHALL be issued;
  - gnt SHALL drop and cnt SHALL hold;
  - ptr SHALL remain the aborted winner.
- REQ-025: Without DELAY_SCHED_ABORT_EN, req[winner] low during RUN SHALL be ignored, and the delay SHALL run to completion with a done pulse.

Structure
- REQ-026: Package delay_sched_pkg SHALL hold:
  - the state enum (IDLE, RUN, DONE);
  - default constants for NREQ and CW.
- REQ-027: Round-robin selection SHALL be a combinational sub-module rr_arb (inputs req and ptr; outputs one-hot winner and winner index), instantiated once.

Verification
- REQ-028: The bench SHALL cover reset mid-RUN: assert rst while cnt=2 -> gnt=0, busy=0 and cnt=0 immediately; no done pulse.
- REQ-029: The bench SHALL cover a single request: after reset, req=0001 and len0=3 ->
  - gnt=0001 for 3 cycles with cnt=0,1,2;
  - done=0001 for 1 cycle;
  - busy low one cycle later.
- REQ-030: The bench SHALL cover round-robin: req=1111 held, all len=1 -> grant order 0,1,2,3,0.
  - Each grant SHALL be followed by a done pulse.
  - Successive grants SHALL be 3 cycles apart.
- REQ-031: The bench SHALL cover wrap: CW=4, len=0 -> RUN lasts 16 cycles, cnt runs 0..15, then done.
- REQ-032: The bench SHALL cover abort (both builds): with req=0010, len1=5, drop req1 after 2 RUN cycles:
  - with DELAY_SCHED_ABORT_EN: IDLE next edge, no done, cnt=2 held;
  - without it: done at cycle 6.
- REQ-033: The bench SHALL cover a late request: req2 raised during RUN of requester 0 -> no effect until IDLE; granted next, ahead of requester 0 still requesting.

Source files
------------

// File: rtl/delay_sched_pkg.sv
// Shared types and defaults for the delay scheduler: FSM state encoding and
// default requester count / counter width.
package delay_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/delay_sched_rr_arb.sv
// Combinational round-robin arbiter: searches from ptr+1 (mod NREQ) upward and
// returns the first requester found as a one-hot code plus its index.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx
);

    always_comb begin
        int  j;
        logic found;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                win[j]  = 1'b1;
                win_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/delay_sched.sv
// Shared-counter delay scheduler: round-robin grant of one delay counter among
// NREQ requesters. Define DELAY_SCHED_ABORT_EN to let a winner abort by dropping req.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             busy,
    output logic [CW-1:0]    cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   len_q;
    logic [NREQ-1:0] arb_win;
    logic [IW-1:0]   arb_idx;
    logic [CW-1:0]   len_sel;
    logic [CW-1:0]   cnt_last;

    rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .win     (arb_win),
        .win_idx (arb_idx)
    );

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_win[i]) len_sel = len[i*CW +: CW];
        end
    end

    // L=0 makes the terminal count all-ones, giving a full 2^CW-cycle run.
    assign cnt_last = len_q - CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= IW'(NREQ - 1);
            len_q <= '0;
            cnt   <= '0;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    gnt  <= arb_win;
                    busy <= |req;
                    if (|req) begin
                        len_q <= len_sel;
                        cnt   <= '0;
                        ptr   <= arb_idx;
                        state <= RUN;
                    end
                end
                RUN: begin
`ifdef DELAY_SCHED_ABORT_EN
                    if (!req[ptr]) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else
`endif
                    if (cnt == cnt_last) begin
                        done  <= gnt;
                        gnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_sched.sv
// Directed testbench for delay_sched (NREQ=4, CW=4); abort expectations follow
// the DELAY_SCHED_ABORT_EN build macro.
module tb_delay_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  cnt;

    int checks = 0;
    int errors = 0;

    delay_sched #(.NREQ(4), .CW(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .len  (len),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .cnt  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b exp %b", gnt, 4'b0000); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b exp %b", done, 4'b0000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp %b", busy, 1'b0); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp %0d", cnt, 0); end
    endtask

    task automatic test_single;
        pulse_reset();
        len = 16'h0003;
        req = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt[%0d]: got %b exp %b", c, gnt, 4'b0001); end
            checks++; if (cnt !== 4'(c)) begin errors++; $display("FAIL single_cnt[%0d]: got %0d exp %0d", c, cnt, c); end
            checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_nodone[%0d]: got %b exp %b", c, done, 4'b0000); end
        end
        tick();
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b exp %b", done, 4'b0001); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_off: got %b exp %b", gnt, 4'b0000); end
        checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL single_cnt_hold: got %0d exp %0d", cnt, 2); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_done: got %b exp %b", busy, 1'b1); end
        req = 4'b0000;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b exp %b", busy, 1'b0); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_off: got %b exp %b", done, 4'b0000); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt [5];
        exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
        pulse_reset();
        len = 16'h1111;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            checks++; if (gnt !== exp_gnt[g]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b exp %b", g, gnt, exp_gnt[g]); end
            tick();
            checks++; if (done !== exp_gnt[g]) begin errors++; $display("FAIL rr_done[%0d]: got %b exp %b", g, done, exp_gnt[g]); end
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap_gnt[%0d]: got %b exp %b", g, gnt, 4'b0000); end
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d]: got %b exp %b", g, busy, 1'b0); end
            if (g == 4) req = 4'b0000;
        end
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_quiet: got %b exp %b", gnt, 4'b0000); end
    endtask

    task automatic test_wrap;
        len = 16'h0000;
        req = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            tick();
            checks++; if (gnt !== 4'b0001 || cnt !== 4'(c)) begin errors++; $display("FAIL wrap_run[%0d]: got gnt=%b cnt=%0d exp gnt=0001 cnt=%0d", c, gnt, cnt, c); end
        end
        tick();
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL wrap_done: got %b exp %b", done, 4'b0001); end
        checks++; if (cnt !== 4'd15) begin errors++; $display("FAIL wrap_cnt_hold: got %0d exp %0d", cnt, 15); end
        req = 4'b0000;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle: got %b exp %b", busy, 1'b0); end
    endtask

    task automatic test_abort;
        pulse_reset();
        len = 16'h0050;
        req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (gnt !== 4'b0010 || cnt !== 4'(c)) begin errors++; $display("FAIL abort_run[%0d]: got gnt=%b cnt=%0d exp gnt=0010 cnt=%0d", c, gnt, cnt, c); end
        end
        req = 4'b0000;
        tick();
`ifdef DELAY_SCHED_ABORT_EN
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL abort_idle: got busy=%b gnt=%b exp busy=0 gnt=0000", busy, gnt); end
        checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL abort_cnt_hold: got %0d exp %0d", cnt, 2); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (done !== 4'b0000) begin errors++; $display("FAIL abort_nodone[%0d]: got %b exp %b", c, done, 4'b0000); end
            tick();
        end
`else
        checks++; if (gnt !== 4'b0010 || cnt !== 4'd3) begin errors++; $display("FAIL noabort_run3: got gnt=%b cnt=%0d exp gnt=0010 cnt=3", gnt, cnt); end
        tick();
        checks++; if (gnt !== 4'b0010 || cnt !== 4'd4) begin errors++; $display("FAIL noabort_run4: got gnt=%b cnt=%0d exp gnt=0010 cnt=4", gnt, cnt); end
        tick();
        checks++; if (done !== 4'b0010) begin errors++; $display("FAIL noabort_done: got %b exp %b", done, 4'b0010); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noabort_idle: got %b exp %b", busy, 1'b0); end
`endif
        // ptr now points at requester 1, so requester 2 must beat requester 1
        len = 16'h0100;
        req = 4'b0110;
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL abort_ptr_next: got %b exp %b", gnt, 4'b0100); end
        tick();
        checks++; if (done !== 4'b0100) begin errors++; $display("FAIL abort_ptr_done: got %b exp %b", done, 4'b0100); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_late;
        len = 16'h0103;
        req = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL late_gnt0: got %b exp %b", gnt, 4'b0001); end
        req = 4'b0101;
        tick();
        checks++; if (gnt !== 4'b0001 || cnt !== 4'd1) begin errors++; $display("FAIL late_hold1: got gnt=%b cnt=%0d exp gnt=0001 cnt=1", gnt, cnt); end
        tick();
        checks++; if (gnt !== 4'b0001 || cnt !== 4'd2) begin errors++; $display("FAIL late_hold2: got gnt=%b cnt=%0d exp gnt=0001 cnt=2", gnt, cnt); end
        tick();
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL late_done0: got %b exp %b", done, 4'b0001); end
        tick();
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL late_idle: got busy=%b gnt=%b exp busy=0 gnt=0000", busy, gnt); end
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL late_gnt2: got %b exp %b", gnt, 4'b0100); end
        tick();
        checks++; if (done !== 4'b0100) begin errors++; $display("FAIL late_done2: got %b exp %b", done, 4'b0100); end
        req = 4'b0000;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL late_end_idle: got %b exp %b", busy, 1'b0); end
    endtask

    task automatic test_reset_mid_run;
        len = 16'h0005;
        req = 4'b0001;
        for (int c = 0; c < 3; c++) tick();
        checks++; if (cnt !== 4'd2 || gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_pre: got gnt=%b cnt=%0d exp gnt=0001 cnt=2", gnt, cnt); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || cnt !== 4'd0) begin errors++; $display("FAIL rstmid_async: got gnt=%b busy=%b cnt=%0d exp gnt=0000 busy=0 cnt=0", gnt, busy, cnt); end
        req = 4'b0000;
        tick();
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL rstmid_nodone: got %b exp %b", done, 4'b0000); end
        rst = 1'b0;
        tick();
        checks++; if (done !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_after: got done=%b busy=%b exp done=0000 busy=0", done, busy); end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        len = '0;
        #1;
        test_reset();
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        test_single();
        test_round_robin();
        test_wrap();
        test_abort();
        test_late();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
